// File: rtl/riscv_pkg.sv
// riscv_pkg: FSM state encoding and the NOP instruction word shared by the
// instruction memory responder and its bench.
package riscv_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} imem_state_e;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/wait_counter.sv
// wait_counter: loadable down-counter that saturates at zero and flags it.
module wait_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/imem_responder.sv
// imem_responder: instruction memory with a fixed-latency fetch response and a loader write port.
// Define IMEM_RANGE_CHK_EN to flag and suppress out-of-range accesses instead of wrapping them.
module imem_responder
  import riscv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WIDTH-1:0]      resp_instr,
  output logic                  resp_err,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LOAD = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  localparam logic [WIDTH-1:0] NOP_W = WIDTH'(NOP);
  logic [WIDTH-1:0] mem [DEPTH];
  imem_state_e state_q, state_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic err_q, err_d;
  logic req_hs, resp_hs, rd_oor, wr_oor, cnt_zero;
  logic [IW-1:0] rd_idx, wr_idx;
  // DEPTH is a power of two, so truncation is the modulo wrap
  assign rd_idx = IW'(req_addr);
  assign wr_idx = IW'(wr_addr);
`ifdef IMEM_RANGE_CHK_EN
  assign rd_oor = 32'(req_addr) >= DEPTH;
  assign wr_oor = 32'(wr_addr) >= DEPTH;
`else
  assign rd_oor = 1'b0;
  assign wr_oor = 1'b0;
`endif
  assign resp_valid = state_q == RESP;
  assign req_ready  = state_q == IDLE || (resp_valid && resp_ready);
  assign req_hs     = req_valid && req_ready;
  assign resp_hs    = resp_valid && resp_ready;
  assign resp_instr = resp_valid ? instr_q : NOP_W;
  assign resp_err   = resp_valid && err_q;
  always_ff @(posedge clk)
    if (wr_en && !wr_oor) mem[wr_idx] <= wr_data;
  wait_counter #(.W(4)) u_wait (
    .clk       (clk),
    .rst       (rst),
    .load_i    (req_hs && WAIT_STATES > 0),
    .load_val_i(LOAD),
    .dec_i     (state_q == WAIT),
    .zero_o    (cnt_zero)
  );
  // the read happens here, before this edge's write lands, giving read-before-write
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    err_d   = err_q;
    if (state_q == WAIT && cnt_zero) state_d = RESP;
    if (resp_hs) state_d = IDLE;
    if (req_hs) begin
      state_d = WAIT_STATES > 0 ? WAIT : RESP;
      instr_d = rd_oor ? NOP_W : mem[rd_idx];
      err_d   = rd_oor;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      instr_q <= NOP_W;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
endmodule
